// File: rtl/data_mem_lsu.sv
// Word-addressed data memory with a byte/half/word load/store front end and
// valid/ready request/response channels. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_mem_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IdxW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [IdxW+1:0]  addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [MEM_SIZE];

  logic [IdxW-1:0]  idx;
  logic [1:0]       off;
  logic             err;
  logic [3:0]       strb;
  logic [31:0]      wlane, wmask, rword, merged, load_val;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic             mem_we;

  // Address wraps modulo MEM_SIZE, so the high address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:IdxW+2];

  // Datapath for the latched access
  always_comb begin
    idx   = addr_q[IdxW+1:2];
    off   = addr_q[1:0];
    strb  = 4'b1111;
    wlane = wdata_q;
    case (size_q)
      2'b00: begin
        strb  = 4'b0001 << off;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        off   = {addr_q[1], 1'b0};
        strb  = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: off = 2'b00;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    err = (size_q == 2'b11) || ((size_q == 2'b01) && addr_q[0]) ||
          ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    err = (size_q == 2'b11);
`endif
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{strb[i]}};
    end
    rword    = mem_q[idx];
    merged   = (rword & ~wmask) | (wlane & wmask);
    sel_byte = rword[{off, 3'b000} +: 8];
    sel_half = off[1] ? rword[31:16] : rword[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_val = uns_q ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_val = rword;
    endcase
    mem_we = (state_q == StAccess) && we_q && !err && !reset;
  end

  // Control FSM
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = !reset;
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr[IdxW+1:0];
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          state_d = StAccess;
        end
      end
      StAccess: begin
        err_d   = err;
        rdata_d = (err || we_q) ? 32'h0 : load_val;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture needs no reset: only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merged;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu with hand-computed expectations.
module tb_data_mem_lsu;

  localparam logic [1:0] SzB = 2'b00;
  localparam logic [1:0] SzH = 2'b01;
  localparam logic [1:0] SzW = 2'b10;
  localparam logic [1:0] SzX = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_lsu #(
    .ADDR_WIDTH(32),
    .MEM_SIZE  (256)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accepts one request and returns once the response is visible (E1 + 1).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'bx;
    req_addr  = 'x;
    check("lat_e0_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_e1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rd, output logic er);
    issue(we, addr, wdata, size, uns);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    access(1'b1, addr, wdata, size, 1'b0, rd, er);
    check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    access(1'b0, addr, 32'h0, size, uns, rd, er);
    check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    check({tag, "_rdata"}, rd, exp);
  endtask

  initial begin
    logic [31:0] held;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = SzW;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("post_rst_rdata", rsp_rdata, 32'h0);
    check("post_rst_err", {31'h0, rsp_err}, 32'h0);

    store("sw10", 32'h10, 32'hDEADBEEF, SzW, 1'b0);
    load("lw10", 32'h10, SzW, 1'b0, 32'hDEADBEEF, 1'b0);

    store("sb13", 32'h13, 32'hFFFFFF7F, SzB, 1'b0);
    load("lb13", 32'h13, SzB, 1'b0, 32'h0000007F, 1'b0);
    load("lb12", 32'h12, SzB, 1'b0, 32'hFFFFFFAD, 1'b0);
    load("lbu12", 32'h12, SzB, 1'b1, 32'h000000AD, 1'b0);
    load("lw10_b", 32'h10, SzW, 1'b1, 32'h7FADBEEF, 1'b0);

    store("sw20", 32'h20, 32'hCAFEF00D, SzW, 1'b0);
    store("sh22", 32'h22, 32'hABCD8001, SzH, 1'b0);
    load("lh22", 32'h22, SzH, 1'b0, 32'hFFFF8001, 1'b0);
    load("lhu22", 32'h22, SzH, 1'b1, 32'h00008001, 1'b0);
    load("lw20", 32'h20, SzW, 1'b0, 32'h8001F00D, 1'b0);
    load("lbu21", 32'h21, SzB, 1'b1, 32'h000000F0, 1'b0);

    // Response back-pressure
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, SzW, 1'b0);
    held = rsp_rdata;
    check("bp_rdata", held, 32'h7FADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rdata_stable", rsp_rdata, 32'h7FADBEEF);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("bp_done_req_ready", {31'h0, req_ready}, 32'h1);

    // Address wrap: 256 words * 4 + 4 aliases word 1
    store("sw_alias", 32'h404, 32'h0BADF00D, SzW, 1'b0);
    load("lw_alias", 32'h4, SzW, 1'b0, 32'h0BADF00D, 1'b0);

    store("s_illegal", 32'h4, 32'hFFFFFFFF, SzX, 1'b1);
    load("l_illegal", 32'h4, SzX, 1'b0, 32'h0, 1'b1);
    load("lw_after_illegal", 32'h4, SzW, 1'b0, 32'h0BADF00D, 1'b0);

    // Reset during ACCESS of a store suppresses the write
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h4;
    req_wdata = 32'h55555555;
    req_size  = SzW;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_acc_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_acc_req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    load("lw_after_rst_acc", 32'h4, SzW, 1'b0, 32'h0BADF00D, 1'b0);

    // Reset during RESP drops the response
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, SzW, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rsp_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    rsp_ready = 1'b1;

    // Misaligned accesses
    store("sw30", 32'h30, 32'h00000000, SzW, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    store("sw31_mis", 32'h31, 32'h12345678, SzW, 1'b1);
    load("lw30_mis", 32'h30, SzW, 1'b0, 32'h00000000, 1'b0);
    load("lh23_mis", 32'h23, SzH, 1'b0, 32'h0, 1'b1);
`else
    store("sw31_mis", 32'h31, 32'h12345678, SzW, 1'b0);
    load("lw30_mis", 32'h30, SzW, 1'b0, 32'h12345678, 1'b0);
    load("lh23_mis", 32'h23, SzH, 1'b0, 32'hFFFF8001, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
